// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
// One request is outstanding at a time; the response comes back as a single-cycle pulse.
interface dmem_responder_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [2:0]            req_funct3;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one RV32 load/store, waits WAIT_STATES cycles,
// then commits the access to the word array and returns a one-cycle response.
module dmem_responder #(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);

    localparam int         WORDS    = 2 ** (DM_ADDRESS - 2);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       commit;

    logic                  we_p0;
    logic [DM_ADDRESS-1:0] addr_p0;
    logic [DATA_W-1:0]     wdata_p0;
    logic [2:0]            funct3_p0;

    logic                  from_bus;
    logic                  acc_we;
    logic [DM_ADDRESS-1:0] acc_addr;
    logic [DATA_W-1:0]     acc_wdata;
    logic [2:0]            acc_funct3;
    logic [DM_ADDRESS-3:0] widx;
    logic [1:0]            lane;
    logic                  acc_err;
    logic [3:0]            be;
    logic [DATA_W-1:0]     lanes;
    logic [DATA_W-1:0]     rd_word;

    logic [DATA_W-1:0] mem [WORDS];

    logic              rsp_valid_p1;
    logic [DATA_W-1:0] rdata_p1;
    logic              err_p1;

    // Misaligned halves/words, unknown funct3 codes and unsigned stores are rejected.
    function automatic logic access_err(input logic we, input logic [1:0] ln, input logic [2:0] f3);
        case (f3)
            3'd0:    return 1'b0;
            3'd1:    return ln[0];
            3'd2:    return ln != 2'b00;
            3'd4:    return we;
            3'd5:    return we | ln[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] ln, input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 4'b0001 << ln;
            2'd1:    return ln[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the low store bytes across the word so any enabled lane sees its data.
    function automatic logic [DATA_W-1:0] store_lanes(input logic [DATA_W-1:0] wd, input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return {4{wd[7:0]}};
            2'd1:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                      input logic [1:0] ln, input logic [2:0] f3);
        logic [DATA_W-1:0] sh;
        sh = word >> {ln, 3'b000};
        case (f3)
            3'd0:    return {{(DATA_W-8){sh[7]}}, sh[7:0]};
            3'd1:    return {{(DATA_W-16){sh[15]}}, sh[15:0]};
            3'd4:    return {{(DATA_W-8){1'b0}}, sh[7:0]};
            3'd5:    return {{(DATA_W-16){1'b0}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    // Request capture (p0): fields are frozen at the handshake
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && bus.req_valid) begin
            we_p0     <= bus.req_we;
            addr_p0   <= bus.req_addr;
            wdata_p0  <= bus.req_wdata;
            funct3_p0 <= bus.req_funct3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With no wait states the commit edge is the accept edge, so the bus feeds the access directly.
    assign from_bus   = (state_q == ST_IDLE);
    assign acc_we     = from_bus ? bus.req_we     : we_p0;
    assign acc_addr   = from_bus ? bus.req_addr   : addr_p0;
    assign acc_wdata  = from_bus ? bus.req_wdata  : wdata_p0;
    assign acc_funct3 = from_bus ? bus.req_funct3 : funct3_p0;
    assign widx       = acc_addr[DM_ADDRESS-1:2];
    assign lane       = acc_addr[1:0];
    assign acc_err    = access_err(acc_we, lane, acc_funct3);
    assign be         = store_be(lane, acc_funct3);
    assign lanes      = store_lanes(acc_wdata, acc_funct3);
    assign rd_word    = mem[widx];

    // Array commit: reset on the commit edge suppresses the write; the array itself is never cleared
    always_ff @(posedge clk) begin
        if (commit && !reset && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= lanes[8*i +: 8];
            end
        end
    end

    // Response (p1): one-cycle pulse, outputs held at zero outside it
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_p1 <= 1'b0;
            rdata_p1     <= '0;
            err_p1       <= 1'b0;
        end else if (commit) begin
            rsp_valid_p1 <= 1'b1;
            err_p1       <= acc_err;
            rdata_p1     <= (acc_we || acc_err) ? '0 : load_extend(rd_word, lane, acc_funct3);
        end else begin
            rsp_valid_p1 <= 1'b0;
            rdata_p1     <= '0;
            err_p1       <= 1'b0;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_p1;
    assign bus.rsp_rdata = rdata_p1;
    assign bus.rsp_err   = err_p1;

    rsp_single_cycle: assert property (@(posedge clk) disable iff (reset)
        rsp_valid_p1 |=> !rsp_valid_p1);

    rsp_only_in_resp: assert property (@(posedge clk) disable iff (reset)
        rsp_valid_p1 == (state_q == ST_RESP));

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (WAIT_STATES=0 and 1) driven with directed and random
// load/store traffic; a byte-level reference memory predicts every response.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset0, reset1;

    dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) if0 ();
    dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) if1 ();

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset0), .bus(if0.slave));
    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_STATES(1)) dut1 (
        .clk(clk), .reset(reset1), .bus(if1.slave));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   has_acc[2];
    int   la[2];
    logic [7:0] mm0[512];
    logic [7:0] mm1[512];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [34:0] outs(input int w);
        if (w == 0) return {if0.req_ready, if0.rsp_valid, if0.rsp_err, if0.rsp_rdata};
        return {if1.req_ready, if1.rsp_valid, if1.rsp_err, if1.rsp_rdata};
    endfunction

    task automatic drive(input int w, input logic v, input logic we, input logic [8:0] a,
                         input logic [31:0] d, input logic [2:0] f);
        if (w == 0) begin
            if0.req_valid = v; if0.req_we = we; if0.req_addr = a; if0.req_wdata = d; if0.req_funct3 = f;
        end else begin
            if1.req_valid = v; if1.req_we = we; if1.req_addr = a; if1.req_wdata = d; if1.req_funct3 = f;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // Reference: byte-addressed memory, access size from funct3, alignment by modulo.
    task automatic model(input int w, input bit we, input logic [8:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, output logic [31:0] rd, output logic e);
        int size;
        logic [31:0] v;
        logic [7:0] b;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        e = (f3 == 3 || f3 == 6 || f3 == 7) || (we && f3 >= 4) || ((int'(a) % size) != 0);
        rd = 32'd0;
        if (e) return;
        if (we) begin
            for (int i = 0; i < size; i++) begin
                if (w == 0) mm0[int'(a) + i] = wd[8*i +: 8];
                else        mm1[int'(a) + i] = wd[8*i +: 8];
            end
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) begin
                b = (w == 0) ? mm0[int'(a) + i] : mm1[int'(a) + i];
                v = v | (32'(b) << (8 * i));
            end
            if (f3 < 4 && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
            rd = v;
        end
    endtask

    // Waits for IDLE (scrambling inputs while busy), presents the request, predicts its response.
    task automatic issue(input int w, input bit we, input logic [8:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, input bit abort);
        int guard;
        exp_t x;
        guard = 0;
        forever begin
            @(negedge clk);
            if (outs(w)[34]) break;
            drive(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 9'($urandom), $urandom,
                  3'($urandom_range(0, 7)));
            guard++;
            if (guard > 40) begin
                failures++;
                checks++;
                $display("FAIL ready_timeout dut=%0d req_ready=0 for %0d cycles, required 1", w, guard);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1, "req_ready never returned");
            end
        end
        drive(w, 1'b1, we, a, wd, f3);
        la[w] = cyc + 1;
        has_acc[w] = 1'b1;
        if (!abort) begin
            model(w, we, a, wd, f3, x.rdata, x.err);
            x.at = cyc + 1 + w;
            if (w == 0) q0.push_back(x);
            else        q1.push_back(x);
        end
    endtask

    task automatic mon_step(input int w);
        logic [34:0] o;
        bit busy, have;
        exp_t x;
        o = outs(w);
        busy = has_acc[w] && cyc >= la[w] && cyc <= la[w] + w;
        checks++;
        if (o[34] !== (busy ? 1'b0 : 1'b1)) begin
            failures++;
            $display("FAIL req_ready dut=%0d cyc=%0d got=%b required=%b", w, cyc, o[34], !busy);
        end
        have = (w == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) x = (w == 0) ? q0[0] : q1[0];
        if (o[33] === 1'b1) begin
            checks++;
            if (!have) begin
                failures++;
                $display("FAIL unexpected_rsp dut=%0d cyc=%0d got rsp_valid=1 required 0", w, cyc);
            end else begin
                if (w == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
                if (o[31:0] !== x.rdata || o[32] !== x.err || cyc != x.at) begin
                    failures++;
                    $display("FAIL rsp dut=%0d got rdata=%h err=%b cyc=%0d required rdata=%h err=%b cyc=%0d",
                             w, o[31:0], o[32], cyc, x.rdata, x.err, x.at);
                end
            end
        end else begin
            if (have && cyc > x.at) begin
                checks++;
                failures++;
                $display("FAIL missing_rsp dut=%0d cyc=%0d got no rsp_valid required at cyc=%0d", w, cyc, x.at);
                if (w == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
            checks++;
            if (o[33] !== 1'b0 || o[32] !== 1'b0 || o[31:0] !== 32'd0) begin
                failures++;
                $display("FAIL idle_outputs dut=%0d cyc=%0d got valid=%b err=%b rdata=%h required 0/0/0",
                         w, cyc, o[33], o[32], o[31:0]);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            for (int w = 0; w < 2; w++) mon_step(w);
        end
    end

    task automatic run_suite(input int w);
        logic [8:0]  a;
        logic [2:0]  f;
        int          r;
        for (int i = 0; i < 128; i++) issue(w, 1'b1, 9'(i * 4), $urandom, 3'd2, 1'b0);

        issue(w, 1'b1, 9'h010, 32'hDEADBEEF, 3'd2, 1'b0);
        issue(w, 1'b0, 9'h010, 32'd0, 3'd2, 1'b0);
        issue(w, 1'b1, 9'h013, 32'h00000080, 3'd0, 1'b0);
        issue(w, 1'b0, 9'h013, 32'd0, 3'd0, 1'b0);
        issue(w, 1'b0, 9'h013, 32'd0, 3'd4, 1'b0);
        issue(w, 1'b0, 9'h010, 32'd0, 3'd2, 1'b0);
        issue(w, 1'b1, 9'h020, 32'd0, 3'd2, 1'b0);
        issue(w, 1'b1, 9'h022, 32'h00008001, 3'd1, 1'b0);
        issue(w, 1'b0, 9'h022, 32'd0, 3'd1, 1'b0);
        issue(w, 1'b0, 9'h020, 32'd0, 3'd5, 1'b0);
        issue(w, 1'b0, 9'h011, 32'd0, 3'd2, 1'b0);
        issue(w, 1'b1, 9'h015, 32'h0000ABCD, 3'd1, 1'b0);
        issue(w, 1'b0, 9'h014, 32'd0, 3'd2, 1'b0);
        issue(w, 1'b1, 9'h040, 32'h00000055, 3'd4, 1'b0);
        issue(w, 1'b1, 9'h040, 32'h00005555, 3'd5, 1'b0);
        issue(w, 1'b0, 9'h040, 32'd0, 3'd3, 1'b0);
        issue(w, 1'b0, 9'h040, 32'd0, 3'd6, 1'b0);
        issue(w, 1'b1, 9'h040, 32'h12345678, 3'd7, 1'b0);
        issue(w, 1'b0, 9'h043, 32'd0, 3'd1, 1'b0);
        issue(w, 1'b0, 9'h041, 32'd0, 3'd5, 1'b0);
        issue(w, 1'b0, 9'h042, 32'd0, 3'd2, 1'b0);
        issue(w, 1'b0, 9'h040, 32'd0, 3'd2, 1'b0);

        if (w == 1) begin
            // Reset during WAIT: the store must vanish without a response.
            issue(1, 1'b1, 9'h030, 32'h0BADF00D, 3'd2, 1'b1);
            @(negedge clk);
            reset1 = 1'b1;
            drive(1, 1'b0, 1'b0, 9'd0, 32'd0, 3'd0);
            has_acc[1] = 1'b0;
            @(negedge clk);
            reset1 = 1'b0;
            issue(1, 1'b0, 9'h030, 32'd0, 3'd2, 1'b0);
            // Reset during RESP: the response has been seen and the store persists.
            issue(1, 1'b1, 9'h034, 32'hCAFEF00D, 3'd2, 1'b0);
            @(negedge clk);
            drive(1, 1'b0, 1'b0, 9'd0, 32'd0, 3'd0);
            @(negedge clk);
            reset1 = 1'b1;
            @(negedge clk);
            reset1 = 1'b0;
            issue(1, 1'b0, 9'h034, 32'd0, 3'd2, 1'b0);
        end

        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 19);
            case (r % 5)
                0: f = 3'd0;
                1: f = 3'd1;
                2: f = 3'd2;
                3: f = 3'd4;
                default: f = 3'd5;
            endcase
            if (r >= 18) f = (r == 18) ? 3'd3 : 3'd6 + 3'($urandom_range(0, 1));
            a = 9'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (f[1:0] == 2'd1) a[0] = 1'b0;
                if (f[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            issue(w, 1'($urandom_range(0, 1)), a, $urandom, f, 1'b0);
        end
        @(negedge clk);
        drive(w, 1'b0, 1'b0, 9'd0, 32'd0, 3'd0);
    endtask

    initial begin
        has_acc[0] = 1'b0;
        has_acc[1] = 1'b0;
        la[0] = 0;
        la[1] = 0;
        reset0 = 1'b1;
        reset1 = 1'b1;
        drive(0, 1'b0, 1'b0, 9'd0, 32'd0, 3'd0);
        drive(1, 1'b0, 1'b0, 9'd0, 32'd0, 3'd0);
        repeat (3) @(negedge clk);
        reset0 = 1'b0;
        reset1 = 1'b0;
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("reset_req_ready_dut%0d", w), 32'(outs(w)[34]), 32'd1);
            chk($sformatf("reset_rsp_valid_dut%0d", w), 32'(outs(w)[33]), 32'd0);
            chk($sformatf("reset_rsp_err_dut%0d", w), 32'(outs(w)[32]), 32'd0);
            chk($sformatf("reset_rsp_rdata_dut%0d", w), outs(w)[31:0], 32'd0);
        end
        mon_en = 1'b1;

        run_suite(1);
        run_suite(0);

        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d/%0d required 0/0", q0.size(), q1.size());
        end
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
